toast_if_id_buffer: RTL and testbench

Two-entry instruction buffer between the fetch stage and the decode stage. It captures each fetched instruction with its PC, predecodes control-flow class, and presents entries to ID in order over a valid/ready handshake. Stalls are absorbed without re-fetch, and a flush discards everything in flight. Outputs come only from registers, so there is no combinational path from IF inputs to ID outputs.

---
 rtl/toast_if_id_buffer_pkg.sv | 38 +++
 rtl/toast_predecode.sv | 17 +
 rtl/toast_if_id_buffer.sv | 119 +++++++++++
 tb/tb_toast_if_id_buffer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/toast_if_id_buffer_pkg.sv
// Shared widths, RV32 opcode constants and payload types for the IF/ID buffer.
package toast_if_id_buffer_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned OPC_W          = 7;
  localparam int unsigned DEPTH          = 2;
  localparam int unsigned CNT_W          = 2;

  localparam logic [REG_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  // Control-flow class produced by the predecoder.
  typedef struct packed {
    logic is_branch;
    logic is_jal;
    logic is_jalr;
  } predecode_t;

  // One buffer slot: instruction, its PC and the predecoded class.
  typedef struct packed {
    logic [REG_DATA_WIDTH-1:0] instr;
    logic [REG_DATA_WIDTH-1:0] pc;
    predecode_t                flags;
  } slot_t;

  // Contents of a cleared slot, also what ID sees when the buffer is empty.
  function automatic slot_t empty_slot();
    slot_t s;
    s.instr = NOP_INSTR;
    s.pc    = '0;
    s.flags = '0;
    return s;
  endfunction

endpackage

// File: rtl/toast_predecode.sv
// Combinational opcode classifier; shared with the branch-prediction logic.
module toast_predecode
  import toast_if_id_buffer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output predecode_t       flags_c
);

  // Decode the major opcode into control-flow flags.
  always_comb begin
    flags_c           = '0;
    flags_c.is_branch = (opcode_i == OPC_BRANCH);
    flags_c.is_jal    = (opcode_i == OPC_JAL);
    flags_c.is_jalr   = (opcode_i == OPC_JALR);
  end

endmodule

// File: rtl/toast_if_id_buffer.sv
// Two-entry IF->ID instruction buffer with predecode, stall absorption and flush.
module toast_if_id_buffer
  import toast_if_id_buffer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      IF_valid_i,
  output logic                      IF_ready_o,
  input  logic [REG_DATA_WIDTH-1:0] IF_instruction_i,
  input  logic [REG_DATA_WIDTH-1:0] IF_pc_i,
  output logic                      ID_valid_o,
  input  logic                      ID_ready_i,
  output logic [REG_DATA_WIDTH-1:0] ID_instruction_o,
  output logic [REG_DATA_WIDTH-1:0] ID_pc_o,
  output logic                      ID_is_branch_o,
  output logic                      ID_is_jal_o,
  output logic                      ID_is_jalr_o,
  input  logic                      flush_i,
  output logic [CNT_W-1:0]          occupancy_o
);

  slot_t            slot_q [DEPTH];
  slot_t            slot_n [DEPTH];
  logic             wr_ptr_q, wr_ptr_n;
  logic             rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0] count_q, count_n;

  // Registered ID-facing head and handshake flags, derived from next state.
  slot_t            head_q, head_n;
  logic             if_ready_q, if_ready_n;
  logic             id_valid_q, id_valid_n;

  predecode_t       pd_c;
  slot_t            new_slot_c;
  logic             push_c;
  logic             pop_c;

  toast_predecode u_predecode (
    .opcode_i (IF_instruction_i[OPC_W-1:0]),
    .flags_c  (pd_c)
  );

  // Handshakes: flush cancels both sides; readiness depends only on count.
  always_comb begin
    push_c           = IF_valid_i & (count_q < CNT_W'(DEPTH)) & ~flush_i;
    pop_c            = (count_q != '0) & ID_ready_i & ~flush_i;
    new_slot_c       = '0;
    new_slot_c.instr = IF_instruction_i;
    new_slot_c.pc    = IF_pc_i;
    new_slot_c.flags = pd_c;
  end

  // Next-state for slots, pointers, count and the registered head view.
  always_comb begin
    slot_n   = slot_q;
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;

    if (flush_i) begin
      wr_ptr_n = 1'b0;
      rd_ptr_n = 1'b0;
      count_n  = '0;
    end else begin
      if (push_c) begin
        slot_n[wr_ptr_q] = new_slot_c;
        wr_ptr_n         = ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_n = ~rd_ptr_q;
      end
      case ({push_c, pop_c})
        2'b10:   count_n = count_q + CNT_W'(1);
        2'b01:   count_n = count_q - CNT_W'(1);
        default: count_n = count_q;
      endcase
    end

    // Empty buffer presents a NOP so stale slots never leak to ID.
    head_n     = (count_n != '0) ? slot_n[rd_ptr_n] : empty_slot();
    if_ready_n = (count_n < CNT_W'(DEPTH));
    id_valid_n = (count_n != '0);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= empty_slot();
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      head_q     <= empty_slot();
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= slot_n[i];
      end
      wr_ptr_q   <= wr_ptr_n;
      rd_ptr_q   <= rd_ptr_n;
      count_q    <= count_n;
      head_q     <= head_n;
      if_ready_q <= if_ready_n;
      id_valid_q <= id_valid_n;
    end
  end

  assign IF_ready_o       = if_ready_q;
  assign ID_valid_o       = id_valid_q;
  assign ID_instruction_o = head_q.instr;
  assign ID_pc_o          = head_q.pc;
  assign ID_is_branch_o   = head_q.flags.is_branch;
  assign ID_is_jal_o      = head_q.flags.is_jal;
  assign ID_is_jalr_o     = head_q.flags.is_jalr;
  assign occupancy_o      = count_q;

endmodule

// File: tb/tb_toast_if_id_buffer.sv
// Directed plus random stimulus against a queue-based model of the IF/ID buffer.
module tb_toast_if_id_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        IF_valid_i;
  logic        IF_ready_o;
  logic [31:0] IF_instruction_i;
  logic [31:0] IF_pc_i;
  logic        ID_valid_o;
  logic        ID_ready_i;
  logic [31:0] ID_instruction_o;
  logic [31:0] ID_pc_o;
  logic        ID_is_branch_o;
  logic        ID_is_jal_o;
  logic        ID_is_jalr_o;
  logic        flush_i;
  logic [1:0]  occupancy_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] q_instr [$];
  logic [31:0] q_pc    [$];

  toast_if_id_buffer dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .IF_valid_i       (IF_valid_i),
    .IF_ready_o       (IF_ready_o),
    .IF_instruction_i (IF_instruction_i),
    .IF_pc_i          (IF_pc_i),
    .ID_valid_o       (ID_valid_o),
    .ID_ready_i       (ID_ready_i),
    .ID_instruction_o (ID_instruction_o),
    .ID_pc_o          (ID_pc_o),
    .ID_is_branch_o   (ID_is_branch_o),
    .ID_is_jal_o      (ID_is_jal_o),
    .ID_is_jalr_o     (ID_is_jalr_o),
    .flush_i          (flush_i),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model queue implies.
  task automatic check_all(input string tag);
    logic [31:0] ei, ep;
    logic [6:0]  op;
    int          n;
    n  = q_instr.size();
    ei = (n != 0) ? q_instr[0] : 32'h0000_0013;
    ep = (n != 0) ? q_pc[0]    : 32'h0;
    op = ei[6:0];
    chk({tag, ".occ"},    32'(occupancy_o), 32'(n));
    chk({tag, ".ready"},  32'(IF_ready_o),  32'(n < 2));
    chk({tag, ".valid"},  32'(ID_valid_o),  32'(n != 0));
    chk({tag, ".instr"},  ID_instruction_o, ei);
    chk({tag, ".pc"},     ID_pc_o,          ep);
    chk({tag, ".br"},     32'(ID_is_branch_o), 32'((n != 0) && op == 7'h63));
    chk({tag, ".jal"},    32'(ID_is_jal_o),    32'((n != 0) && op == 7'h6F));
    chk({tag, ".jalr"},   32'(ID_is_jalr_o),   32'((n != 0) && op == 7'h67));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl, input logic rst, input string tag);
    bit push, pop;
    IF_valid_i       = v;
    IF_instruction_i = ins;
    IF_pc_i          = pc;
    ID_ready_i       = rdy;
    flush_i          = fl;
    reset_i          = rst;
    push = v && (q_instr.size() < 2) && !fl;
    pop  = rdy && (q_instr.size() > 0) && !fl;
    @(posedge clk_i);
    #1;
    if (rst || fl) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (push) begin
        q_instr.push_back(ins);
        q_pc.push_back(pc);
      end
    end
    check_all(tag);
  endtask

  logic [31:0] rnd_instr;
  logic [6:0]  opc_tab [4];

  initial begin
    opc_tab[0] = 7'h63; opc_tab[1] = 7'h6F; opc_tab[2] = 7'h67; opc_tab[3] = 7'h13;
    IF_valid_i = 0; IF_instruction_i = 0; IF_pc_i = 0;
    ID_ready_i = 0; flush_i = 0; reset_i = 1;

    // Reset and idle.
    cyc(0, 0, 0, 0, 0, 1, "reset");
    cyc(0, 0, 0, 0, 0, 0, "idle");
    cyc(0, 0, 0, 1, 0, 0, "idle_pop_empty");

    // Single push, then ID consumes it.
    cyc(1, 32'h00A00093, 32'h100, 1, 0, 0, "push1");
    cyc(0, 0, 0, 1, 0, 0, "pop1");

    // Fill while ID stalls, third offer rejected, then drain in order.
    cyc(1, 32'h00000063, 32'h104, 0, 0, 0, "fill_a");
    cyc(1, 32'h0080006F, 32'h108, 0, 0, 0, "fill_b");
    cyc(1, 32'h000000E7, 32'h10C, 0, 0, 0, "full_offer");
    cyc(0, 0, 0, 1, 0, 0, "drain_a");
    cyc(0, 0, 0, 1, 0, 0, "drain_b");

    // Streaming with simultaneous push/pop.
    for (int i = 0; i < 8; i++)
      cyc(1, 32'h00100093 + 32'(i << 20), 32'h200 + 32'(4 * i), 1, 0, 0, "stream");
    cyc(0, 0, 0, 1, 0, 0, "stream_tail");

    // Full, then flush with a same-cycle push.
    cyc(1, 32'h00000063, 32'h300, 0, 0, 0, "pre_flush_a");
    cyc(1, 32'h00000067, 32'h304, 0, 0, 0, "pre_flush_b");
    cyc(1, 32'h0000006F, 32'h308, 1, 1, 0, "flush");
    cyc(0, 0, 0, 0, 0, 0, "post_flush");

    // Reset while full, then a fresh push.
    cyc(1, 32'h00000013, 32'h400, 0, 0, 0, "pre_rst_a");
    cyc(1, 32'h00000063, 32'h404, 0, 0, 0, "pre_rst_b");
    cyc(1, 32'h0000006F, 32'h408, 1, 0, 1, "mid_reset");
    cyc(1, 32'h000000E7, 32'h500, 0, 0, 0, "post_rst_push");
    cyc(0, 0, 0, 1, 0, 0, "post_rst_pop");

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rnd_instr = {$urandom()} & 32'hFFFF_FF80;
      rnd_instr = rnd_instr | 32'(opc_tab[$urandom_range(3, 0)]);
      cyc(1'($urandom_range(1, 0)), rnd_instr, 32'h1000 + 32'(4 * i),
          1'($urandom_range(1, 0)), ($urandom_range(19, 0) == 0),
          ($urandom_range(49, 0) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
